imem_loader: RTL and testbench

- Writer side of the CPU's instruction memory. Receives a framed byte stream over a valid/ready handshake, for example from a UART receiver.
- Assembles little-endian 32-bit words and writes them into instruction memory through a single write port.
- Holds the CPU in reset (active-low output) until a complete, valid image has been written.
- Replaces the fixed $readmemh image load with a runtime download path.

---
 rtl/imem_loader.sv | 167 ++++++++++++++++
 tb/tb_imem_loader.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction-memory download port: framed byte stream in, 32-bit word writes out.
// Optional checksum trailer enabled by defining CHECKSUM_EN.
module imem_loader #(
   parameter int          DEPTH     = 2048,
   parameter int          ADDR_W    = 13,
   parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic [7:0]        byte_i,
   input  logic              byte_valid_i,
   output logic              byte_ready_o,
   output logic              imem_we_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   output logic [31:0]       imem_wdata_o,
   output logic              cpu_reset_no,
   output logic              busy_o,
   output logic              done_o,
   output logic              error_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_DONE, S_ERROR
`ifdef CHECKSUM_EN
      , S_CSUM
`endif
   } state_t;

   localparam logic [15:0] DEPTH_L = 16'(DEPTH);

   state_t              state_q, state_d;
   logic [15:0]         len_q, len_d;
   logic [15:0]         wcnt_q, wcnt_d;
   logic [1:0]          bidx_q, bidx_d;
   logic [23:0]         asm_q, asm_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic                ready_q, we_q, cpu_rst_n_q, busy_q, done_q, err_q;
   logic                fire;
`ifdef CHECKSUM_EN
   logic [7:0]          csum_q, csum_d;
`endif

   assign fire = byte_valid_i & ready_q;

   // Where the payload ends: straight to DONE, or via the checksum byte.
   state_t end_state;
`ifdef CHECKSUM_EN
   assign end_state = S_CSUM;
`else
   assign end_state = S_DONE;
`endif

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      wcnt_d  = wcnt_q;
      bidx_d  = bidx_q;
      asm_d   = asm_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
`ifdef CHECKSUM_EN
      csum_d  = csum_q;
`endif
      case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (fire && byte_i == SYNC_BYTE) state_d = S_LEN0;
         end
         S_LEN0: begin
            if (fire) begin
               len_d[7:0] = byte_i;
               state_d    = S_LEN1;
            end
         end
         S_LEN1: begin
            if (fire) begin
               len_d  = {byte_i, len_q[7:0]};
               wcnt_d = '0;
               bidx_d = '0;
               if (len_d == 16'd0)        state_d = end_state;
               else if (len_d > DEPTH_L)  state_d = S_ERROR;
               else                       state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (fire) begin
               bidx_d = bidx_q + 2'd1;
`ifdef CHECKSUM_EN
               csum_d = csum_q ^ byte_i;
`endif
               case (bidx_q)
                  2'd0: asm_d[7:0]   = byte_i;
                  2'd1: asm_d[15:8]  = byte_i;
                  2'd2: asm_d[23:16] = byte_i;
                  default: begin
                     wdata_d = {byte_i, asm_q};
                     addr_d  = wcnt_q[ADDR_W-1:0];
                     state_d = S_WRITE;
                  end
               endcase
            end
         end
         S_WRITE: begin
            wcnt_d  = wcnt_q + 16'd1;
            state_d = (wcnt_d == len_q) ? end_state : S_DATA;
         end
`ifdef CHECKSUM_EN
         S_CSUM: begin
            if (fire) state_d = (byte_i == csum_q) ? S_DONE : S_ERROR;
         end
`endif
         default: state_d = S_IDLE;
      endcase
`ifdef CHECKSUM_EN
      if (state_d == S_LEN0) csum_d = '0;
`endif
   end

   // Status outputs are registered from the next state so they track the FSM exactly.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= S_IDLE;
         len_q       <= '0;
         wcnt_q      <= '0;
         bidx_q      <= '0;
         asm_q       <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         ready_q     <= 1'b0;
         we_q        <= 1'b0;
         cpu_rst_n_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
`ifdef CHECKSUM_EN
         csum_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         wcnt_q      <= wcnt_d;
         bidx_q      <= bidx_d;
         asm_q       <= asm_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         ready_q     <= (state_d != S_WRITE);
         we_q        <= (state_d == S_WRITE);
         cpu_rst_n_q <= (state_d == S_DONE);
         busy_q      <= !(state_d inside {S_IDLE, S_DONE, S_ERROR});
         done_q      <= (state_d == S_DONE);
         err_q       <= (state_d == S_ERROR);
`ifdef CHECKSUM_EN
         csum_q      <= csum_d;
`endif
      end
   end

   assign byte_ready_o = ready_q;
   assign imem_we_o    = we_q;
   assign imem_addr_o  = addr_q;
   assign imem_wdata_o = wdata_q;
   assign cpu_reset_no = cpu_rst_n_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign error_o      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed frames; expected writes queued by the stimulus and checked by a write monitor.
module tb_imem_loader;
   localparam int ADDR_W = 13;

   logic              clk = 1'b0;
   logic              reset_i;
   logic [7:0]        byte_i;
   logic              byte_valid_i;
   logic              byte_ready_o, imem_we_o, cpu_reset_no, busy_o, done_o, error_o;
   logic [ADDR_W-1:0] imem_addr_o;
   logic [31:0]       imem_wdata_o;

   int checks = 0;
   int passes = 0;
   logic [44:0] exp_q[$];
   logic [31:0] fw[$];
   logic        prev_we = 1'b0;

   imem_loader #(.DEPTH(2048), .ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
      .clock_i(clk), .reset_i(reset_i), .byte_i(byte_i), .byte_valid_i(byte_valid_i),
      .byte_ready_o(byte_ready_o), .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o),
      .imem_wdata_o(imem_wdata_o), .cpu_reset_no(cpu_reset_no), .busy_o(busy_o),
      .done_o(done_o), .error_o(error_o));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Write monitor: every strobe must match the oldest queued expectation.
   always @(negedge clk) begin
      if (reset_i) prev_we = 1'b0;
      else begin
         if (imem_we_o) begin
            check("we_single_pulse", 64'(prev_we), 64'd0);
            check("ready_low_on_write", 64'(byte_ready_o), 64'd0);
            check("write_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
               logic [44:0] e;
               e = exp_q.pop_front();
               check("write_addr", 64'(imem_addr_o), 64'(e[44:32]));
               check("write_data", 64'(imem_wdata_o), 64'(e[31:0]));
            end
         end
         prev_we = imem_we_o;
      end
   end

   // Called at a negedge; returns at the negedge after the accepting edge with valid dropped.
   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      byte_i = b;
      byte_valid_i = 1'b1;
      while (!byte_ready_o && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) check("ready_timeout", 64'(n), 64'd0);
      @(negedge clk);
      byte_valid_i = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] csum_flip);
      int len;
      logic [7:0] cs;
      logic [31:0] w;
      len = fw.size();
      cs = 8'h00;
      send_byte(8'hA5);
      send_byte(len[7:0]);
      send_byte(len[15:8]);
      for (int i = 0; i < len; i++) begin
         w = fw[i];
         exp_q.push_back({13'(i), w});
         for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8]);
            cs ^= w[8*k +: 8];
         end
      end
`ifdef CHECKSUM_EN
      send_byte(cs ^ csum_flip);
`else
      if (csum_flip != 8'h00) cs = csum_flip;
`endif
      fw.delete();
   endtask

   task automatic check_status(input string tag, input logic d, input logic e, input logic c, input logic b);
      check({tag, "_done"},  64'(done_o),       64'(d));
      check({tag, "_error"}, 64'(error_o),      64'(e));
      check({tag, "_cpurn"}, 64'(cpu_reset_no), 64'(c));
      check({tag, "_busy"},  64'(busy_o),       64'(b));
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_we"},    64'(imem_we_o),    64'd0);
      check({tag, "_addr"},  64'(imem_addr_o),  64'd0);
      check({tag, "_wdata"}, 64'(imem_wdata_o), 64'd0);
      check({tag, "_ready"}, 64'(byte_ready_o), 64'd0);
      check_status(tag, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_i = 1'b1;
      byte_i = 8'h00;
      byte_valid_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_reset_vals("rst");
      reset_i = 1'b0;
      @(negedge clk);
      check("ready_after_reset", 64'(byte_ready_o), 64'd1);

      // Basic two-word load
      fw.push_back(32'h0000_0013);
      fw.push_back(32'h0010_0093);
      send_frame(8'h00);
      @(negedge clk);
      check_status("basic", 1'b1, 1'b0, 1'b1, 1'b0);

      // Junk bytes are swallowed in DONE
      foreach (fw[i]) fw.delete();
      send_byte(8'h00);
      check("junk_ready0", 64'(byte_ready_o), 64'd1);
      send_byte(8'hFF);
      check("junk_ready1", 64'(byte_ready_o), 64'd1);
      send_byte(8'h3C);
      check("junk_ready2", 64'(byte_ready_o), 64'd1);
      check_status("junk", 1'b1, 1'b0, 1'b1, 1'b0);

      // Empty frame; SYNC drops done/cpu release in the same update
      send_byte(8'hA5);
      check_status("resync", 1'b0, 1'b0, 1'b0, 1'b1);
      send_byte(8'h00);
      send_byte(8'h00);
`ifdef CHECKSUM_EN
      send_byte(8'h00);
`endif
      check_status("empty", 1'b1, 1'b0, 1'b1, 1'b0);
      check("empty_ready", 64'(byte_ready_o), 64'd1);

      // Oversize length 2049 rejected
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h08);
      check_status("oversize", 1'b0, 1'b1, 1'b0, 1'b0);

      // Recovery frame
      fw.push_back(32'hDEAD_BEEF);
      send_frame(8'h00);
      @(negedge clk);
      check_status("recover", 1'b1, 1'b0, 1'b1, 1'b0);

      // Three words streamed back-to-back; WRITE cycles stall the stream
      fw.push_back(32'h1122_3344);
      fw.push_back(32'hA5A5_0000);
      fw.push_back(32'hFFFF_FFFF);
      send_frame(8'h00);
      @(negedge clk);
      check_status("stream", 1'b1, 1'b0, 1'b1, 1'b0);

      // Asynchronous reset after two data bytes of a one-word frame
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'h11);
      send_byte(8'h22);
      #2 reset_i = 1'b1;
      #1 check_reset_vals("midrst");
      @(negedge clk);
      reset_i = 1'b0;
      @(negedge clk);
      fw.push_back(32'h1234_5678);
      send_frame(8'h00);
      @(negedge clk);
      check_status("fresh", 1'b1, 1'b0, 1'b1, 1'b0);

`ifdef CHECKSUM_EN
      fw.push_back(32'h0000_0013);
      send_frame(8'h00);
      @(negedge clk);
      check_status("csum_ok", 1'b1, 1'b0, 1'b1, 1'b0);
      fw.push_back(32'h0000_0013);
      send_frame(8'h01);
      @(negedge clk);
      check_status("csum_bad", 1'b0, 1'b1, 1'b0, 1'b0);
`endif

      repeat (3) @(negedge clk);
      check("pending_writes", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
